ddc_mix_decim: RTL and testbench

//  Quadrature mixer plus integrate-and-dump decimator. Sits directly downstream of the
//  DDC NCO: multiplies each ADC sample by the NCO cos/sin pair (I = x*cos, Q = -x*sin),

---
 rtl/ddc_pkg.sv | 25 ++
 rtl/ddc_intdump.sv | 44 ++++
 rtl/ddc_mix_decim.sv | 120 ++++++++++++
 tb/tb_ddc_mix_decim.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// Shared DDC types and width helpers for the NCO wrapper, mixer/decimator and downstream filters.
// Sample widths here are the defaults; modules take them as overridable parameters.
package ddc_pkg;

    localparam int DAT_W_DEF  = 12;
    localparam int NCO_W_DEF  = 12;
    localparam int PROD_W_DEF = DAT_W_DEF + NCO_W_DEF;

    function automatic int clog2(input int v);
        int r;
        int t;
        r = 0;
        t = v - 1;
        while (t > 0) begin
            r = r + 1;
            t = t >> 1;
        end
        return r;
    endfunction

    typedef logic signed [DAT_W_DEF-1:0]  sample_t;
    typedef logic signed [NCO_W_DEF-1:0]  nco_t;
    typedef logic signed [PROD_W_DEF-1:0] prod_t;

endpackage

// File: rtl/ddc_intdump.sv
// One integrate-and-dump channel: sums products, dumps the truncated top OUT_W bits.
// Latency: 1 cycle from the final product to dat. No backpressure; clken freezes all state.
module ddc_intdump
    import ddc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = PROD_W_DEF + 3,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clken,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     dump,
    input  logic signed [PROD_W-1:0] p,
    output logic signed [OUT_W-1:0]  dat
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    assign sum = acc + ACC_W'(p);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            dat <= '0;
        end else if (clken) begin
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                if (dump) begin
                    // Dropping low bits of a signed value is a floor, not round-to-zero.
                    dat <= sum[ACC_W-1 -: OUT_W];
                    acc <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/ddc_mix_decim.sv
// Quadrature mixer (I = x*cos, Q = -x*sin) followed by DEC_R:1 integrate-and-dump.
// Latency: 3 clken-high cycles from the DEC_R-th accepted sample to out_valid. No backpressure.
module ddc_mix_decim
    import ddc_pkg::*;
#(
    parameter int DAT_W = DAT_W_DEF,
    parameter int NCO_W = NCO_W_DEF,
    parameter int DEC_R = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    dec_clr,
    input  logic signed [DAT_W-1:0] adc_i,
    input  logic                    adc_valid,
    input  logic signed [NCO_W-1:0] nco_cos_i,
    input  logic signed [NCO_W-1:0] nco_sin_i,
    input  logic                    nco_valid,
    output logic signed [OUT_W-1:0] i_o,
    output logic signed [OUT_W-1:0] q_o,
    output logic                    out_valid
);

    localparam int PROD_W = DAT_W + NCO_W;
    localparam int ACC_W  = PROD_W + clog2(DEC_R);
    localparam int CNT_W  = clog2(DEC_R);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_R - 1);

    logic signed [DAT_W-1:0]  x_r;
    logic signed [NCO_W-1:0]  cos_r;
    logic signed [NCO_W-1:0]  sin_r;
    logic                     v1;
    logic                     v2;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] cos_ext;
    logic signed [PROD_W-1:0] sin_ext;
    logic signed [PROD_W-1:0] p_i;
    logic signed [PROD_W-1:0] p_q;
    logic [CNT_W-1:0]         cnt;
    logic                     accept;
    logic                     dump;

    assign accept  = adc_valid & nco_valid & ~dec_clr;
    assign x_ext   = PROD_W'(x_r);
    assign cos_ext = PROD_W'(cos_r);
    assign sin_ext = PROD_W'(sin_r);
    assign dump    = v2 & (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r   <= '0;
            cos_r <= '0;
            sin_r <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            p_i   <= '0;
            p_q   <= '0;
        end else if (clken) begin
            v1 <= accept;
            v2 <= v1 & ~dec_clr;
            if (accept) begin
                x_r   <= adc_i;
                cos_r <= nco_cos_i;
                sin_r <= nco_sin_i;
            end
            // Full-width product; -(-2^(W-1))^2 still fits, so the negation cannot wrap.
            p_i <= x_ext * cos_ext;
            p_q <= -(x_ext * sin_ext);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (clken) begin
            if (dec_clr) begin
                cnt       <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= dump;
                if (v2) begin
                    cnt <= dump ? '0 : cnt + 1'b1;
                end
            end
        end
    end

    ddc_intdump #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_int_i (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .clr   (dec_clr),
        .en    (v2),
        .dump  (dump),
        .p     (p_i),
        .dat   (i_o)
    );

    ddc_intdump #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_int_q (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .clr   (dec_clr),
        .en    (v2),
        .dump  (dump),
        .p     (p_q),
        .dat   (q_o)
    );

endmodule

// File: tb/tb_ddc_mix_decim.sv
// Directed bench for ddc_mix_decim at DEC_R=4, OUT_W=16 (ACC_W=26, dump shift 10).
module tb_ddc_mix_decim;

    logic               clk = 1'b0;
    logic               reset;
    logic               clken;
    logic               dec_clr;
    logic signed [11:0] adc_i;
    logic               adc_valid;
    logic signed [11:0] nco_cos_i;
    logic signed [11:0] nco_sin_i;
    logic               nco_valid;
    logic signed [15:0] i_o;
    logic signed [15:0] q_o;
    logic               out_valid;

    int errs  = 0;
    int n_chk = 0;

    ddc_mix_decim #(
        .DAT_W (12),
        .NCO_W (12),
        .DEC_R (4),
        .OUT_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .dec_clr   (dec_clr),
        .adc_i     (adc_i),
        .adc_valid (adc_valid),
        .nco_cos_i (nco_cos_i),
        .nco_sin_i (nco_sin_i),
        .nco_valid (nco_valid),
        .i_o       (i_o),
        .q_o       (q_o),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int x, input int c, input int s, input logic av, input logic nv);
        adc_i     = 12'(x);
        nco_cos_i = 12'(c);
        nco_sin_i = 12'(s);
        adc_valid = av;
        nco_valid = nv;
    endtask

    // Holds inputs for nt edges; strobe expected on tick first, first+per, ...
    task automatic run_expect(input string tag, input int nt, input int first, input int per,
                              input int ei, input int eq);
        for (int n = 1; n <= nt; n++) begin
            logic exp_v;
            tick();
            exp_v = (n >= first) && (((n - first) % per) == 0);
            chk({tag, "_vld"}, int'(out_valid), int'(exp_v));
            if (exp_v) begin
                chk({tag, "_i"}, int'(i_o), ei);
                chk({tag, "_q"}, int'(q_o), eq);
            end
        end
    endtask

    task automatic clear_phase();
        dec_clr   = 1'b1;
        adc_valid = 1'b0;
        tick();
        dec_clr   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        clken   = 1'b1;
        dec_clr = 1'b0;
        set_in(0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_i", int'(i_o), 0);
        chk("rst_q", int'(q_o), 0);
        chk("rst_vld", int'(out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1: 100*2047*4 = 818800, >>10 = 799
        set_in(100, 2047, 0, 1'b1, 1'b1);
        run_expect("c1", 10, 6, 4, 799, 0);
        clear_phase();

        // 2: -(-2048*-2048)*4 = -2^24, >>10 = -16384
        set_in(-2048, 0, -2048, 1'b1, 1'b1);
        run_expect("c2", 6, 6, 4, 0, -16384);
        clear_phase();
        chk("c2_hold_q", int'(q_o), -16384);
        chk("c2_clr_vld", int'(out_valid), 0);

        // 3: clken low 5 cycles mid-block delays the strobe
        set_in(100, 2047, 0, 1'b1, 1'b1);
        tick();
        tick();
        clken = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("c3_gap_vld", int'(out_valid), 0);
        end
        clken = 1'b1;
        run_expect("c3", 4, 4, 4, 799, 0);
        clken = 1'b0;
        tick();
        chk("c3_hold_vld", int'(out_valid), 1);
        tick();
        chk("c3_hold_vld", int'(out_valid), 1);
        clken = 1'b1;
        tick();
        chk("c3_drop_vld", int'(out_valid), 0);
        clear_phase();

        // 4: dec_clr after 2 samples with a sample presented the same cycle
        set_in(100, 2047, 0, 1'b1, 1'b1);
        tick();
        tick();
        dec_clr = 1'b1;
        tick();
        chk("c4_clr_vld", int'(out_valid), 0);
        dec_clr = 1'b0;
        run_expect("c4", 6, 6, 4, 799, 0);
        clear_phase();

        // 5: adc_valid toggling, accepted on odd ticks -> strobes on ticks 9 and 17
        set_in(100, 2047, 0, 1'b1, 1'b1);
        for (int n = 1; n <= 17; n++) begin
            adc_valid = n[0];
            tick();
            chk("c5_vld", int'(out_valid), int'(n == 9 || n == 17));
            if (n == 9 || n == 17) begin
                chk("c5_i", int'(i_o), 799);
                chk("c5_q", int'(q_o), 0);
            end
        end
        // one sample pending; nco_valid low must block further acceptance
        set_in(100, 2047, 0, 1'b1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("c5_nco_blk", int'(out_valid), 0);
        end
        nco_valid = 1'b1;
        run_expect("c5_resume", 5, 5, 4, 799, 0);
        clear_phase();

        // 6: async reset between edges mid-block
        set_in(-2048, 0, -2048, 1'b1, 1'b1);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("c6_rst_i", int'(i_o), 0);
        chk("c6_rst_q", int'(q_o), 0);
        chk("c6_rst_vld", int'(out_valid), 0);
        tick();
        #2;
        reset = 1'b0;
        set_in(100, 2047, 0, 1'b1, 1'b1);
        run_expect("c6", 6, 6, 4, 799, 0);

        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule
